// File: rtl/cpu_pkg.sv
// Shared widths and the fetch-buffer entry payload used by the fetch stage.
package cpu_pkg;

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned PC_W    = 32;

   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instruction;
   } fetch_entry_t;

   localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; DEPTH must be a power of two so the
// pointers wrap naturally. The head entry is read straight from storage.
module fetch_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 64,
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] din,
   output logic             full_c,
   output logic             empty_c,
   output logic [CNT_W-1:0] count,
   output logic [WIDTH-1:0] head_c
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             pop_eff_c;
   logic             push_eff_c;

   assign empty_c    = (count == '0);
   assign full_c     = (count == CNT_W'(DEPTH));
   assign pop_eff_c  = pop & !empty_c;
   assign push_eff_c = push & (!full_c | pop_eff_c);
   assign head_c     = mem[rd_ptr];

   // Flush only rewinds pointers; stale storage is never visible while empty.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_eff_c) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (pop_eff_c) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push_eff_c, pop_eff_c})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, reads IMem, buffers words for decode, handles
// redirect/flush and end of program. INSTR_FETCH_PERF_EN adds perf counters.
module instr_fetch
   import cpu_pkg::*;
#(
   parameter int unsigned     NUM_INSTRUCTIONS = 256,
   parameter int unsigned     BUF_DEPTH        = 2,
   parameter logic [PC_W-1:0] RESET_PC         = '0
) (
   input  logic               i_clk,
   input  logic               i_rst,
   output logic [PC_W-1:0]    o_imem_pc,
   input  logic [INSTR_W-1:0] i_imem_instruction,
   output logic               o_valid,
   input  logic               i_ready,
   output logic [INSTR_W-1:0] o_instruction,
   output logic [PC_W-1:0]    o_inst_pc,
   input  logic               i_redirect,
   input  logic [PC_W-1:0]    i_redirect_pc,
`ifdef INSTR_FETCH_PERF_EN
   output logic [31:0]        o_fetch_count,
   output logic [31:0]        o_stall_count,
`endif
   output logic               o_done
);

   localparam int unsigned     CNT_W  = $clog2(BUF_DEPTH) + 1;
   localparam logic [PC_W-1:0] END_PC = PC_W'(NUM_INSTRUCTIONS);

   logic [PC_W-1:0]  fetch_pc;
   logic [PC_W-1:0]  pc_next_c;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] cnt_next_c;
   logic             done_next_c;
   logic             full_c;
   logic             empty_c;
   logic             pop_c;
   logic             push_c;
   fetch_entry_t     push_entry_c;
   fetch_entry_t     head_entry_c;
   logic [ENTRY_W-1:0] head_raw_c;

   assign pop_c        = o_valid & i_ready;
   assign push_c       = !i_redirect & (fetch_pc < END_PC) & (!full_c | pop_c);
   assign push_entry_c = '{pc: fetch_pc, instruction: i_imem_instruction};
   assign head_entry_c = fetch_entry_t'(head_raw_c);

   assign o_imem_pc     = fetch_pc;
   assign o_valid       = !empty_c;
   assign o_instruction = head_entry_c.instruction;
   assign o_inst_pc     = head_entry_c.pc;

   fetch_fifo #(
      .DEPTH (BUF_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk     (i_clk),
      .rst     (i_rst),
      .push    (push_c),
      .pop     (pop_c & !i_redirect),
      .flush   (i_redirect),
      .din     (push_entry_c),
      .full_c  (full_c),
      .empty_c (empty_c),
      .count   (count),
      .head_c  (head_raw_c)
   );

   // Look ahead one edge so o_done is a plain register.
   always_comb begin
      pc_next_c  = fetch_pc;
      cnt_next_c = count;
      if (i_redirect) begin
         pc_next_c  = i_redirect_pc;
         cnt_next_c = '0;
      end else begin
         if (push_c) pc_next_c = fetch_pc + PC_W'(1);
         cnt_next_c = count + CNT_W'(push_c) - CNT_W'(pop_c);
      end
      done_next_c = (pc_next_c >= END_PC) & (cnt_next_c == '0);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         fetch_pc <= RESET_PC;
         o_done   <= (RESET_PC >= END_PC);
      end else begin
         fetch_pc <= pc_next_c;
         o_done   <= done_next_c;
      end
   end

`ifdef INSTR_FETCH_PERF_EN
   // Counters survive redirects; only reset clears them.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_fetch_count <= '0;
         o_stall_count <= '0;
      end else begin
         if (push_c && (o_fetch_count != 32'hFFFF_FFFF))
            o_fetch_count <= o_fetch_count + 32'd1;
         if (full_c && !pop_c && !o_done)
            o_stall_count <= o_stall_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus random traffic, checked
// every cycle against a queue-based model of the fetch stream.
module tb_instr_fetch;

   localparam int unsigned NUM   = 11;
   localparam int unsigned DEPTH = 2;

   logic        i_clk;
   logic        i_rst;
   logic [31:0] o_imem_pc;
   logic [31:0] i_imem_instruction;
   logic        o_valid;
   logic        i_ready;
   logic [31:0] o_instruction;
   logic [31:0] o_inst_pc;
   logic        i_redirect;
   logic [31:0] i_redirect_pc;
   logic        o_done;
`ifdef INSTR_FETCH_PERF_EN
   logic [31:0] o_fetch_count;
   logic [31:0] o_stall_count;
`endif

   int n_cmp = 0;
   int n_err = 0;

   instr_fetch #(
      .NUM_INSTRUCTIONS (NUM),
      .BUF_DEPTH        (DEPTH),
      .RESET_PC         (32'd0)
   ) dut (
      .i_clk              (i_clk),
      .i_rst              (i_rst),
      .o_imem_pc          (o_imem_pc),
      .i_imem_instruction (i_imem_instruction),
      .o_valid            (o_valid),
      .i_ready            (i_ready),
      .o_instruction      (o_instruction),
      .o_inst_pc          (o_inst_pc),
      .i_redirect         (i_redirect),
      .i_redirect_pc      (i_redirect_pc),
`ifdef INSTR_FETCH_PERF_EN
      .o_fetch_count      (o_fetch_count),
      .o_stall_count      (o_stall_count),
`endif
      .o_done             (o_done)
   );

   // IMem: combinational word for each index
   assign i_imem_instruction = 32'h1000 + o_imem_pc;

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   // Reference model: a queue of in-flight PCs plus the next PC to fetch.
   logic [31:0] m_q[$];
   logic [31:0] m_pc;
   bit          m_done;
   bit          m_ok = 1'b0;
   bit          m_pop;
   bit          m_push;
   logic [31:0] m_fc;
   logic [31:0] m_sc;

   always @(posedge i_clk) begin
      if (i_rst) begin
         m_q.delete();
         m_pc   = 32'd0;
         m_done = 1'b0;
         m_fc   = 32'd0;
         m_sc   = 32'd0;
         m_ok   = 1'b1;
      end else if (m_ok) begin
         if (m_q.size() == DEPTH && !i_ready && !m_done) m_sc = m_sc + 32'd1;
         if (i_redirect) begin
            m_q.delete();
            m_pc = i_redirect_pc;
         end else begin
            m_pop  = (m_q.size() > 0) && i_ready;
            m_push = (m_pc < NUM) && ((m_q.size() < DEPTH) || m_pop);
            if (m_pop) void'(m_q.pop_front());
            if (m_push) begin
               m_q.push_back(m_pc);
               m_pc = m_pc + 32'd1;
               if (m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 32'd1;
            end
         end
         m_done = (m_pc >= NUM) && (m_q.size() == 0);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
      end
   endtask

   // Advance to the next falling edge and compare all outputs to the model.
   task automatic tick();
      @(negedge i_clk);
      if (m_ok) begin
         chk("model.imem_pc", o_imem_pc, m_pc);
         chk("model.valid", 32'(o_valid), 32'(m_q.size() != 0));
         if (m_q.size() != 0) begin
            chk("model.inst_pc", o_inst_pc, m_q[0]);
            chk("model.instruction", o_instruction, 32'h1000 + m_q[0]);
         end
         chk("model.done", 32'(o_done), 32'(m_done));
`ifdef INSTR_FETCH_PERF_EN
         chk("model.fetch_count", o_fetch_count, m_fc);
         chk("model.stall_count", o_stall_count, m_sc);
`endif
      end
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
   endtask

   initial begin
      i_rst         = 1'b1;
      i_ready       = 1'b0;
      i_redirect    = 1'b0;
      i_redirect_pc = 32'd0;

      // Reset values, then streaming with decode always ready
      tick();
      tick();
      chk("rst.valid", 32'(o_valid), 32'd0);
      chk("rst.imem_pc", o_imem_pc, 32'd0);
      chk("rst.done", 32'(o_done), 32'd0);
      chk("rst.instruction", o_instruction, 32'd0);
      chk("rst.inst_pc", o_inst_pc, 32'd0);
      i_rst   = 1'b0;
      i_ready = 1'b1;
      for (int i = 0; i <= 10; i++) begin
         tick();
         chk("stream.valid", 32'(o_valid), 32'd1);
         chk("stream.inst_pc", o_inst_pc, 32'(i));
         chk("stream.instruction", o_instruction, 32'h1000 + 32'(i));
      end
      tick();
      chk("stream.done", 32'(o_done), 32'd1);
      chk("stream.empty", 32'(o_valid), 32'd0);

      // Back-pressure: buffer fills to DEPTH and fetch stalls
      i_ready = 1'b0;
      do_reset();
      repeat (5) tick();
      chk("stall.imem_pc", o_imem_pc, 32'd2);
      chk("stall.inst_pc", o_inst_pc, 32'd0);
      i_ready = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         chk("resume.inst_pc", o_inst_pc, 32'(i));
      end

      // Redirect while full with head PC 3, ready asserted on the same edge
      do_reset();
      repeat (4) tick();
      i_ready = 1'b0;
      tick();
      chk("full.inst_pc", o_inst_pc, 32'd3);
      chk("full.imem_pc", o_imem_pc, 32'd5);
      i_redirect    = 1'b1;
      i_redirect_pc = 32'd7;
      i_ready       = 1'b1;
      tick();
      i_redirect = 1'b0;
      chk("redir.valid", 32'(o_valid), 32'd0);
      chk("redir.imem_pc", o_imem_pc, 32'd7);
      for (int i = 7; i <= 10; i++) begin
         tick();
         chk("redir.inst_pc", o_inst_pc, 32'(i));
      end
      tick();
      chk("redir.done", 32'(o_done), 32'd1);

      // Out-of-range redirect halts, in-range redirect replays from 0
      i_redirect    = 1'b1;
      i_redirect_pc = 32'd20;
      tick();
      i_redirect = 1'b0;
      chk("oor.valid", 32'(o_valid), 32'd0);
      chk("oor.done", 32'(o_done), 32'd1);
      tick();
      chk("oor.done_hold", 32'(o_done), 32'd1);
      i_redirect    = 1'b1;
      i_redirect_pc = 32'd0;
      tick();
      i_redirect = 1'b0;
      chk("replay.done", 32'(o_done), 32'd0);
      tick();
      chk("replay.inst_pc", o_inst_pc, 32'd0);

      // Reset pulse mid-stream at head PC 5
      repeat (5) tick();
      chk("mid.inst_pc", o_inst_pc, 32'd5);
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      chk("mid.valid", 32'(o_valid), 32'd0);
      chk("mid.imem_pc", o_imem_pc, 32'd0);
`ifdef INSTR_FETCH_PERF_EN
      chk("mid.fetch_count", o_fetch_count, 32'd0);
`endif
      tick();
      chk("mid.restart", o_inst_pc, 32'd0);

      // Random traffic against the model
      for (int c = 0; c < 2000; c++) begin
         tick();
         i_rst         = ($urandom_range(0, 99) < 2);
         i_redirect    = ($urandom_range(0, 99) < 8);
         i_redirect_pc = 32'($urandom_range(0, 14));
         i_ready       = ($urandom_range(0, 99) < 70);
      end
      i_rst      = 1'b0;
      i_redirect = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
